// File: rtl/kmp_matcher.sv
// kmp_matcher: Knuth-Morris-Pratt search of one pattern over a bounded string.
// Reports the start index of the first occurrence once per i_valid request.
module kmp_matcher #(
    parameter int BYTE        = 8,
    parameter int MAX_PATTERN = 8,
    parameter int MAX_PAT_ADD = 3,
    parameter int MAX_STRING  = 32,
    parameter int MAX_STR_ADD = 5
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               i_valid,
    input  logic [MAX_PATTERN*BYTE-1:0]        pattern,
    input  logic [MAX_PAT_ADD-1:0]             last_pat_idx,
    input  logic [MAX_PAT_ADD*MAX_PATTERN-1:0] fail_func,
    input  logic [MAX_STRING*BYTE-1:0]         str,
    input  logic [MAX_STR_ADD-1:0]             last_str_idx,
    output logic                               o_match,
    output logic [MAX_STR_ADD-1:0]             o_match_idx,
    output logic                               o_valid
);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        SCAN = 3'b010,
        DONE = 3'b100
    } state_t;

    state_t state, state_nxt;

    logic [MAX_STR_ADD-1:0] str_ptr, str_ptr_nxt;
    logic [MAX_PAT_ADD-1:0] pat_ptr, pat_ptr_nxt;
    logic [MAX_PAT_ADD-1:0] pat_prev;
    logic [MAX_STR_ADD-1:0] idx_nxt;
    logic [MAX_STR_ADD-1:0] pat_last_ext;
    logic                   match_nxt;
    logic                   valid_nxt;
    logic                   chars_eq;

    logic [BYTE-1:0]        pat_ch   [MAX_PATTERN];
    logic [MAX_PAT_ADD-1:0] fail_ent [MAX_PATTERN];
    logic [BYTE-1:0]        str_ch   [MAX_STRING];

    for (genvar k = 0; k < MAX_PATTERN; k++) begin : g_pat
        assign pat_ch[k]   = pattern[k*BYTE +: BYTE];
        assign fail_ent[k] = fail_func[k*MAX_PAT_ADD +: MAX_PAT_ADD];
    end

    for (genvar n = 0; n < MAX_STRING; n++) begin : g_str
        assign str_ch[n] = str[n*BYTE +: BYTE];
    end

    assign pat_last_ext = MAX_STR_ADD'(last_pat_idx);
    assign pat_prev     = pat_ptr - MAX_PAT_ADD'(1);
    assign chars_eq     = (str_ch[str_ptr] == pat_ch[pat_ptr]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            str_ptr     <= '0;
            pat_ptr     <= '0;
            o_match     <= 1'b0;
            o_match_idx <= '0;
            o_valid     <= 1'b0;
        end else begin
            state       <= state_nxt;
            str_ptr     <= str_ptr_nxt;
            pat_ptr     <= pat_ptr_nxt;
            o_match     <= match_nxt;
            o_match_idx <= idx_nxt;
            o_valid     <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        str_ptr_nxt = str_ptr;
        pat_ptr_nxt = pat_ptr;
        match_nxt   = o_match;
        idx_nxt     = o_match_idx;
        valid_nxt   = o_valid;
        case (state)
            IDLE: begin
                valid_nxt = 1'b0;
                if (i_valid) begin
                    state_nxt   = SCAN;
                    str_ptr_nxt = '0;
                    pat_ptr_nxt = '0;
                    match_nxt   = 1'b0;
                    idx_nxt     = '0;
                end
            end
            SCAN: begin
                if (!i_valid) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                end else if (pat_last_ext > last_str_idx) begin
                    state_nxt = DONE;
                    valid_nxt = 1'b1;
                    match_nxt = 1'b0;
                    idx_nxt   = '0;
                end else if (chars_eq && pat_ptr == last_pat_idx) begin
                    state_nxt = DONE;
                    valid_nxt = 1'b1;
                    match_nxt = 1'b1;
                    idx_nxt   = str_ptr - pat_last_ext;
                end else if (chars_eq && str_ptr == last_str_idx) begin
                    state_nxt = DONE;
                    valid_nxt = 1'b1;
                    match_nxt = 1'b0;
                    idx_nxt   = '0;
                end else if (chars_eq) begin
                    str_ptr_nxt = str_ptr + MAX_STR_ADD'(1);
                    pat_ptr_nxt = pat_ptr + MAX_PAT_ADD'(1);
                end else if (pat_ptr != '0) begin
                    // fall back along the prefix function; text position is kept
                    pat_ptr_nxt = fail_ent[pat_prev];
                end else if (str_ptr == last_str_idx) begin
                    state_nxt = DONE;
                    valid_nxt = 1'b1;
                    match_nxt = 1'b0;
                    idx_nxt   = '0;
                end else begin
                    str_ptr_nxt = str_ptr + MAX_STR_ADD'(1);
                end
            end
            DONE: begin
                if (!i_valid) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_kmp_matcher.sv
// tb_kmp_matcher: directed and randomized checks of kmp_matcher
// against a brute-force first-occurrence search model.
module tb_kmp_matcher;

    logic         clk;
    logic         reset;
    logic         i_valid;
    logic [63:0]  pattern;
    logic [2:0]   last_pat_idx;
    logic [23:0]  fail_func;
    logic [255:0] str;
    logic [4:0]   last_str_idx;
    logic         o_match;
    logic [4:0]   o_match_idx;
    logic         o_valid;

    int checks = 0;
    int errors = 0;

    byte unsigned pat_a [8];
    byte unsigned str_a [32];
    int plen;
    int slen;

    kmp_matcher dut (
        .clk          (clk),
        .reset        (reset),
        .i_valid      (i_valid),
        .pattern      (pattern),
        .last_pat_idx (last_pat_idx),
        .fail_func    (fail_func),
        .str          (str),
        .last_str_idx (last_str_idx),
        .o_match      (o_match),
        .o_match_idx  (o_match_idx),
        .o_valid      (o_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // longest proper border of pat_a[0..k], by brute force
    function automatic int border(input int k);
        int best;
        bit ok;
        best = 0;
        for (int l = 1; l <= k; l++) begin
            ok = 1'b1;
            for (int j = 0; j < l; j++)
                if (pat_a[j] != pat_a[k - l + 1 + j]) ok = 1'b0;
            if (ok) best = l;
        end
        return best;
    endfunction

    function automatic int model_first();
        bit ok;
        if (plen > slen) return -1;
        for (int i = 0; i <= slen - plen; i++) begin
            ok = 1'b1;
            for (int j = 0; j < plen; j++)
                if (str_a[i + j] != pat_a[j]) ok = 1'b0;
            if (ok) return i;
        end
        return -1;
    endfunction

    task automatic apply_job();
        for (int k = 0; k < 8; k++) begin
            pattern[k*8 +: 8] = pat_a[k];
            fail_func[k*3 +: 3] = (k < plen) ? 3'(border(k)) : 3'd0;
        end
        for (int n = 0; n < 32; n++)
            str[n*8 +: 8] = str_a[n];
        last_pat_idx = 3'(plen - 1);
        last_str_idx = 5'(slen - 1);
    endtask

    // unused tail positions get 'A'/'B' junk so stray reads would match
    task automatic set_text(input string p, input string s);
        plen = p.len();
        slen = s.len();
        for (int k = 0; k < 8; k++)
            pat_a[k] = (k < plen) ? p[k] : 8'(8'h41 + $urandom_range(0, 1));
        for (int n = 0; n < 32; n++)
            str_a[n] = (n < slen) ? s[n] : 8'(8'h41 + $urandom_range(0, 1));
        apply_job();
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!o_valid && cyc < 80);
    endtask

    task automatic end_job();
        i_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        checks++;
        if (o_valid !== 1'b0 || o_match !== 1'b0 || o_match_idx !== 5'd0) begin
            errors++;
            $display("FAIL reset_hold: v=%b m=%b idx=%0d want 0 0 0",
                     o_valid, o_match, o_match_idx);
        end
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_match !== 1'b0 || o_match_idx !== 5'd0) begin
            errors++;
            $display("FAIL reset_idle: v=%b m=%b idx=%0d want 0 0 0",
                     o_valid, o_match, o_match_idx);
        end
    endtask

    task automatic test_abab();
        int cyc;
        set_text("ABAB", "ABAABABAB");
        i_valid = 1'b1;
        wait_done(cyc);
        checks++;
        if (o_valid !== 1'b1 || o_match !== 1'b1 || o_match_idx !== 5'd3) begin
            errors++;
            $display("FAIL abab: v=%b m=%b idx=%0d want 1 1 3",
                     o_valid, o_match, o_match_idx);
        end
        checks++;
        if (cyc - 1 > 18) begin
            errors++;
            $display("FAIL abab_latency: scan cycles %0d want <= 18", cyc - 1);
        end
        end_job();
    endtask

    task automatic test_aaaa();
        int cyc;
        set_text("AAAA", "AAABAAAB");
        i_valid = 1'b1;
        wait_done(cyc);
        checks++;
        if (o_valid !== 1'b1 || o_match !== 1'b0 || o_match_idx !== 5'd0) begin
            errors++;
            $display("FAIL aaaa: v=%b m=%b idx=%0d want 1 0 0",
                     o_valid, o_match, o_match_idx);
        end
        end_job();
    endtask

    task automatic test_single();
        int cyc;
        set_text("C", "XYC");
        i_valid = 1'b1;
        wait_done(cyc);
        checks++;
        if (o_valid !== 1'b1 || o_match !== 1'b1 || o_match_idx !== 5'd2) begin
            errors++;
            $display("FAIL single: v=%b m=%b idx=%0d want 1 1 2",
                     o_valid, o_match, o_match_idx);
        end
        checks++;
        if (cyc - 1 > 3) begin
            errors++;
            $display("FAIL single_latency: scan cycles %0d want <= 3", cyc - 1);
        end
        end_job();
    endtask

    task automatic test_too_long();
        int cyc;
        set_text("ABABAB", "ABAB");
        i_valid = 1'b1;
        wait_done(cyc);
        checks++;
        if (o_valid !== 1'b1 || o_match !== 1'b0 || cyc != 2) begin
            errors++;
            $display("FAIL too_long: v=%b m=%b cycles=%0d want 1 0 2",
                     o_valid, o_match, cyc);
        end
        end_job();
    endtask

    task automatic test_release();
        int cyc;
        set_text("ABAB", "ABAABABAB");
        i_valid = 1'b1;
        wait_done(cyc);
        i_valid = 1'b0;
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_match !== 1'b1 || o_match_idx !== 5'd3) begin
            errors++;
            $display("FAIL release: v=%b m=%b idx=%0d want 0 1 3",
                     o_valid, o_match, o_match_idx);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int cyc;
        set_text("ABAB", "ABAABABAB");
        i_valid = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_match !== 1'b0 || o_match_idx !== 5'd0) begin
            errors++;
            $display("FAIL reset_mid: v=%b m=%b idx=%0d want 0 0 0",
                     o_valid, o_match, o_match_idx);
        end
        reset = 1'b1;
        wait_done(cyc);
        checks++;
        if (o_valid !== 1'b1 || o_match !== 1'b1 || o_match_idx !== 5'd3) begin
            errors++;
            $display("FAIL rescan: v=%b m=%b idx=%0d want 1 1 3",
                     o_valid, o_match, o_match_idx);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_match !== 1'b0 || o_match_idx !== 5'd0) begin
            errors++;
            $display("FAIL reset_done: v=%b m=%b idx=%0d want 0 0 0",
                     o_valid, o_match, o_match_idx);
        end
        i_valid = 1'b0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_abort();
        int seen;
        seen = 0;
        set_text("ABAB", "ABAABABAB");
        i_valid = 1'b1;
        tick();
        tick();
        tick();
        i_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (o_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort: o_valid high %0d cycles want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        set_text("BA", "AAAB");
        i_valid = 1'b1;
        wait_done(cyc);
        checks++;
        if (o_valid !== 1'b1 || o_match !== 1'b0 || o_match_idx !== 5'd0) begin
            errors++;
            $display("FAIL b2b_first: v=%b m=%b idx=%0d want 1 0 0",
                     o_valid, o_match, o_match_idx);
        end
        end_job();
        set_text("AB", "AAAB");
        i_valid = 1'b1;
        wait_done(cyc);
        checks++;
        if (o_valid !== 1'b1 || o_match !== 1'b1 || o_match_idx !== 5'd2) begin
            errors++;
            $display("FAIL b2b_second: v=%b m=%b idx=%0d want 1 1 2",
                     o_valid, o_match, o_match_idx);
        end
        end_job();
    endtask

    task automatic test_random();
        int cyc;
        int exp;
        int bound;
        int span;
        for (int it = 0; it < 80; it++) begin
            plen = $urandom_range(1, 8);
            slen = (it % 4 == 0) ? $urandom_range(1, 8) : $urandom_range(1, 32);
            span = (it % 3 == 0) ? 2 : 1;
            for (int k = 0; k < 8; k++)
                pat_a[k] = 8'(8'h41 + $urandom_range(0, span));
            for (int n = 0; n < 32; n++)
                str_a[n] = 8'(8'h41 + $urandom_range(0, span));
            apply_job();
            exp = model_first();
            bound = (plen > slen) ? 1 : 2 * slen;
            i_valid = 1'b1;
            wait_done(cyc);
            checks++;
            if (o_valid !== 1'b1 || o_match !== (exp >= 0)
                || o_match_idx !== ((exp >= 0) ? 5'(exp) : 5'd0)) begin
                errors++;
                $display("FAIL random_%0d: v=%b m=%b idx=%0d want 1 %0d %0d",
                         it, o_valid, o_match, o_match_idx,
                         exp >= 0, (exp >= 0) ? exp : 0);
            end
            checks++;
            if (cyc - 1 > bound) begin
                errors++;
                $display("FAIL random_latency_%0d: scan cycles %0d want <= %0d",
                         it, cyc - 1, bound);
            end
            end_job();
        end
    endtask

    initial begin
        reset = 1'b0;
        i_valid = 1'b0;
        pattern = '0;
        fail_func = '0;
        str = '0;
        last_pat_idx = '0;
        last_str_idx = '0;
        plen = 1;
        slen = 1;
        tick();
        tick();
        test_reset();
        test_abab();
        test_aaaa();
        test_single();
        test_too_long();
        test_release();
        test_reset_mid();
        test_abort();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
